// File: rtl/mux_arbiter.sv
// Two-requester valid/ready arbiter feeding one registered output slot, round-robin with hold limit.
// Define MUX_ARBITER_FIXED_PRIO_EN to give requester A fixed priority instead of round-robin.
module mux_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state_reg, state_next;
  logic [7:0]       hold_cnt_reg, hold_cnt_next;
  logic             last_grant_reg, last_grant_next;
  logic             sel_reg, sel_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;

  logic             can_accept;
  logic             gnt_b;
  logic             in_xfer;
  logic             cur_valid;
  logic             oth_valid;
  logic             hold_wrap;
  logic             preempt;
  state_t           other_state;
  state_t           tie_state;
  logic [WIDTH-1:0] in_data;

  // The slot can take a new word when empty or when it drains this same cycle.
  assign can_accept  = !out_valid_reg || out_ready;
  assign gnt_b       = (state_reg == GNT_B);
  assign a_ready     = (state_reg == GNT_A) && can_accept;
  assign b_ready     = (state_reg == GNT_B) && can_accept;
  assign in_xfer     = (a_valid && a_ready) || (b_valid && b_ready);
  assign in_data     = gnt_b ? b_data : a_data;
  assign cur_valid   = gnt_b ? b_valid : a_valid;
  assign oth_valid   = gnt_b ? a_valid : b_valid;
  assign other_state = gnt_b ? GNT_A : GNT_B;
  assign hold_wrap   = (hold_cnt_reg == HOLD_LAST);

`ifdef MUX_ARBITER_FIXED_PRIO_EN
  // A is never cut short; B gives way to A after every word it moves.
  assign preempt   = gnt_b && oth_valid;
  assign tie_state = GNT_A;
`else
  assign preempt   = hold_wrap && oth_valid;
  assign tie_state = last_grant_reg ? GNT_A : GNT_B;
`endif

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (a_valid && b_valid) state_next = tie_state;
        else if (a_valid)       state_next = GNT_A;
        else if (b_valid)       state_next = GNT_B;
      end
      GNT_A, GNT_B: begin
        if (in_xfer) begin
          if (preempt) begin
            state_next      = other_state;
            hold_cnt_next   = 8'd0;
            last_grant_next = gnt_b;
          end else begin
            hold_cnt_next = hold_wrap ? 8'd0 : hold_cnt_reg + 8'd1;
          end
        end else if (!cur_valid) begin
          state_next      = oth_valid ? other_state : IDLE;
          hold_cnt_next   = 8'd0;
          last_grant_next = gnt_b;
        end
        // Granted side still valid but stalled: hold the grant untouched.
      end
      default: state_next = IDLE;
    endcase

    sel_next = sel_reg;
    case (state_next)
      GNT_A:   sel_next = 1'b0;
      GNT_B:   sel_next = 1'b1;
      default: sel_next = sel_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      hold_cnt_reg   <= 8'd0;
      last_grant_reg <= 1'b1;
      sel_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      last_grant_reg <= last_grant_next;
      sel_reg        <= sel_next;
    end
  end

  // Load and drain in the same cycle simply overwrites the slot, giving one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (in_xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= in_data;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign sel       = sel_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of each requester and the output.
REQ-002 SHALL have parameter MAX_HOLD, default 4, maximum consecutive transfers per grant while the other side waits; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports a_valid  input  1  /  a_data  input  WIDTH  /  a_ready  output  1  requester A handshake.
REQ-006 SHALL have ports b_valid  input  1  /  b_data  input  WIDTH  /  b_ready  output  1  requester B handshake.
REQ-007 SHALL have ports out_valid  output  1  /  out_data  output  WIDTH  /  out_ready  input  1  shared output handshake.
REQ-008 SHALL have port sel  output  1  registered mux select: 0 = A, 1 = B.
REQ-009 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, GNT_A, GNT_B plus registers hold_cnt (8-bit), last_grant (1-bit) and a one-entry output buffer.
REQ-011 Transfer on side X SHALL occur when X_valid && X_ready; output transfer when out_valid && out_ready.
REQ-012 X_ready SHALL equal (state == GNT_X) && (!out_valid || out_ready), combinational; the non-granted side's ready SHALL be 0.
REQ-013 On an input transfer, out_data SHALL load the granted side's data and out_valid SHALL be 1 the next cycle; otherwise an output transfer clears out_valid and out_data holds.
REQ-014 IDLE: only A valid -> GNT_A; only B valid -> GNT_B; both -> side != last_grant; neither -> stay. Arbitration costs one cycle: first input transfer no earlier than cycle N+1, out_valid no earlier than N+2.
REQ-015 sel SHALL update with the state: 0 in GNT_A, 1 in GNT_B, unchanged in IDLE.
REQ-016 GNT_X with transfer: if hold_cnt == MAX_HOLD-1 and other side valid -> GNT_other, hold_cnt=0, last_grant=X; else stay, hold_cnt increments, wrapping MAX_HOLD-1 -> 0.
REQ-017 GNT_X, no transfer, X_valid low: other valid -> GNT_other, else IDLE; hold_cnt=0, last_grant=X.
REQ-018 GNT_X, no transfer, X_valid high (output stalled): stay; hold_cnt unchanged.
REQ-019 Grant SHALL never change in a cycle where the granted side has X_valid high and no transfer occurred.
REQ-020 Simultaneous input and output transfer on a full buffer SHALL replace the entry with no bubble and no loss (full throughput, one word per cycle).
REQ-021 Requesters SHALL hold data stable while valid and not ready; the arbiter does not check this.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, out_valid=0, out_data=0, sel=0, hold_cnt=0, last_grant=B (A wins first tie), busy=0, a_ready=b_ready=0.
REQ-023 Reset mid-transfer SHALL discard buffered data; the first cycle after release behaves as IDLE.

Configuration
REQ-024 Macro MUX_ARBITER_FIXED_PRIO_EN: when defined, IDLE ties always go to A, and A is never preempted by the hold limit (GNT_A releases only per REQ-017); GNT_B yields to a valid A after every B transfer regardless of hold_cnt.
REQ-025 When MUX_ARBITER_FIXED_PRIO_EN is undefined, round-robin per REQ-014/REQ-016 applies; port list is identical in both builds.

Verification
REQ-026 Reset then a_valid=1, a_data=16'h1234, out_ready=1: a_ready high cycle 1, out_valid with out_data=16'h1234 cycle 2, sel=0.
REQ-027 Both valid continuously, out_ready=1, MAX_HOLD=4: output sequence 4xA, 4xB, 4xA, ... with no bubbles after the first word.
REQ-028 GNT_A, out_ready=0 for 5 cycles with buffer full: a_ready=0, out_data stable, no grant change even with b_valid=1; resume yields no lost or duplicated words.
REQ-029 A drops valid after 2 transfers, B valid: switch to GNT_B next cycle, sel=1, hold_cnt=0.
REQ-030 rst_n low while out_valid=1: out_valid=0 asynchronously; after release both valid -> A granted first.
REQ-031 MUX_ARBITER_FIXED_PRIO_EN build, both valid continuously: only A words appear; A deasserts -> B served; A reasserts -> back to A after one B word.
